// File: rtl/bar_display_scheduler_pkg.sv
// bar_display_pkg: shared state encoding and level constants for the bar display scheduler
package bar_display_pkg;
  localparam int LVL_W = 3;
  localparam logic [LVL_W-1:0] LVL_DARK = 3'd0;
  localparam logic [LVL_W-1:0] LVL_FULL = 3'd7;
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
endpackage

// File: rtl/bar_display_scheduler_if.sv
// bar_display_scheduler_if: client-side level write port and scanned display outputs
interface bar_display_scheduler_if
  import bar_display_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int AW = $clog2(N_CH)
);
  logic en;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [LVL_W-1:0] wr_data;
  logic [LVL_W-1:0] level_out;
  logic [N_CH-1:0] digit_sel;
  logic frame_done;
  logic [AW-1:0] cur_ch;
  modport master(output en, wr_en, wr_addr, wr_data, input level_out, digit_sel, frame_done, cur_ch);
  modport slave(input en, wr_en, wr_addr, wr_data, output level_out, digit_sel, frame_done, cur_ch);
endinterface

// File: rtl/bar_display_scheduler_regfile.sv
// bar_level_regfile: per-channel 3-bit level storage, synchronous write, asynchronous read
module bar_level_regfile
  import bar_display_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int AW = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [LVL_W-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [LVL_W-1:0] o_rd_data
);
  logic [LVL_W-1:0] r_mem [N_CH];
  // clear all levels on reset, otherwise store writes that address an existing channel
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < N_CH; i++) r_mem[i] <= LVL_DARK;
    else if (i_wr_en && int'(i_wr_addr) < N_CH) r_mem[i_wr_addr] <= i_wr_data;
  end
  assign o_rd_data = int'(i_rd_addr) < N_CH ? r_mem[i_rd_addr] : LVL_DARK;
endmodule

// File: rtl/bar_display_scheduler.sv
// bar_display_scheduler: round-robin bar scan over one shared decoder; dead time between channels with BAR_DEAD_TIME_EN
module bar_display_scheduler
  import bar_display_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int AW = $clog2(N_CH)
) (
  input logic clk,
  input logic rst,
  bar_display_scheduler_if.slave bus
);
  localparam int DW_W = $clog2(DWELL_CYCLES);
  state_t r_state, w_nxt;
  logic [DW_W-1:0] r_dwell, w_dwell;
  logic [AW-1:0] r_ch, w_ch;
  logic [N_CH-1:0] r_sel;
  logic [LVL_W-1:0] r_lvl, w_rd;
  logic r_frame, w_adv, w_dwell_end, w_last;
  bar_level_regfile #(.N_CH(N_CH), .AW(AW)) u_rf (
    .clk(clk),
    .rst(rst),
    .i_wr_en(bus.wr_en),
    .i_wr_addr(bus.wr_addr),
    .i_wr_data(bus.wr_data),
    .i_rd_addr(r_ch),
    .o_rd_data(w_rd)
  );
  assign w_dwell_end = r_dwell == DW_W'(DWELL_CYCLES - 1);
  assign w_last = r_ch == AW'(N_CH - 1);
`ifdef BAR_DEAD_TIME_EN
  localparam int BL_W = $clog2(BLANK_CYCLES + 1);
  logic [BL_W-1:0] r_blank, w_blank;
  logic w_blank_end;
  assign w_blank_end = r_blank == BL_W'(BLANK_CYCLES - 1);
  // dead-time counter between channels
  always_ff @(posedge clk) begin
    if (rst) r_blank <= '0;
    else r_blank <= w_blank;
  end
`else
  logic w_unused_blank;
  assign w_unused_blank = ^BLANK_CYCLES;
`endif
  // next state, dwell count and channel advance; en low always drops to a dark IDLE
  always_comb begin
    w_nxt = r_state;
    w_dwell = r_dwell;
    w_ch = r_ch;
    w_adv = 1'b0;
`ifdef BAR_DEAD_TIME_EN
    w_blank = r_blank;
`endif
    if (!bus.en) begin
      w_nxt = IDLE;
      w_dwell = '0;
      w_ch = '0;
`ifdef BAR_DEAD_TIME_EN
      w_blank = '0;
`endif
    end else if (r_state == IDLE) begin
      w_nxt = SCAN;
      w_dwell = '0;
      w_ch = '0;
    end else if (r_state == SCAN) begin
      w_dwell = w_dwell_end ? '0 : r_dwell + 1'b1;
`ifdef BAR_DEAD_TIME_EN
      if (w_dwell_end) w_nxt = BLANK;
    end else if (r_state == BLANK) begin
      w_blank = w_blank_end ? '0 : r_blank + 1'b1;
      if (w_blank_end) begin
        w_nxt = SCAN;
        w_adv = 1'b1;
      end
`else
      w_adv = w_dwell_end;
`endif
    end
    if (w_adv) w_ch = w_last ? '0 : r_ch + 1'b1;
  end
  // state and output registers; level is shown only while the same scan stays lit across the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dwell <= '0;
      r_ch <= '0;
      r_sel <= '0;
      r_lvl <= LVL_DARK;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_dwell <= w_dwell;
      r_ch <= w_ch;
      r_sel <= w_nxt == SCAN ? N_CH'(1) << w_ch : '0;
      r_lvl <= r_state == SCAN && w_nxt == SCAN ? w_rd : LVL_DARK;
      r_frame <= w_adv && w_last;
    end
  end
  assign bus.level_out = r_lvl;
  assign bus.digit_sel = r_sel;
  assign bus.frame_done = r_frame;
  assign bus.cur_ch = r_ch;
endmodule

// File: tb/tb_bar_display_scheduler.sv
// tb_bar_display_scheduler: directed checks of scan order, level latency, enable/reset behaviour and invalid writes
module tb_bar_display_scheduler;
  import bar_display_pkg::*;
  localparam int N = 4;
  localparam int DW = 4;
`ifdef BAR_DEAD_TIME_EN
  localparam int BLK = 2;
`else
  localparam int BLK = 0;
`endif
  localparam int P = DW + BLK;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int k = -1;
  int frames = 0;
  logic [2:0] mem [N];
  logic [2:0] m3 [3];
  bar_display_scheduler_if #(.N_CH(N)) b();
  bar_display_scheduler_if #(.N_CH(3)) b3();
  bar_display_scheduler #(.N_CH(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(2)) u (.clk(clk), .rst(rst), .bus(b));
  bar_display_scheduler #(.N_CH(3), .DWELL_CYCLES(DW), .BLANK_CYCLES(2)) u3 (.clk(clk), .rst(rst), .bus(b3));
  always #5 clk = ~clk;

  function automatic int e_sel(int n, int kk);
    if (kk < 0) return 0;
    return kk % P < DW ? 1 << ((kk / P) % n) : 0;
  endfunction
  function automatic int e_idx(int n, int kk);
    if (kk < 1) return -1;
    if ((kk - 1) % P >= DW || kk % P >= DW) return -1;
    return ((kk - 1) / P) % n;
  endfunction
  function automatic int e_frm(int n, int kk);
    return (kk > 0 && kk % (n * P) == 0) ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic e, r, we;
    logic [1:0] wa;
    logic [2:0] wd;
    int i;
    e = b.en; r = rst; we = b.wr_en; wa = b.wr_addr; wd = b.wr_data;
    @(posedge clk); #1;
    k = (r || !e) ? -1 : k + 1;
    i = e_idx(N, k);
    chk("digit_sel", 32'(b.digit_sel), 32'(e_sel(N, k)));
    chk("level_out", 32'(b.level_out), i < 0 ? 0 : 32'(mem[i]));
    chk("frame_done", 32'(b.frame_done), 32'(e_frm(N, k)));
    chk("cur_ch", 32'(b.cur_ch), k < 0 ? 0 : 32'((k / P) % N));
    if (b.frame_done) frames++;
    if (r) foreach (mem[j]) mem[j] = '0;
    else if (we) mem[wa] = wd;
  endtask

  initial begin
    foreach (mem[j]) mem[j] = '0;
    rst = 1'b1;
    b.en = 0; b.wr_en = 0; b.wr_addr = '0; b.wr_data = '0;
    b3.en = 0; b3.wr_en = 0; b3.wr_addr = '0; b3.wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    b.wr_en = 1; b.wr_addr = 2; b.wr_data = 5;
    tick();
    b.wr_en = 0;
    repeat (3) tick();
    for (int c = 0; c < N; c++) begin
      b.wr_en = 1; b.wr_addr = 2'(c); b.wr_data = 3'(2 * c + 1);
      tick();
    end
    b.wr_en = 0;
    b.en = 1;
    tick();
    chk("first_sel", 32'(b.digit_sel), 32'h1);
    frames = 0;
    repeat (2 * N * P) tick();
    chk("frame_count", frames, 2);
    for (int i = 0; i < 4 * N * P && !((k / P) % N == 1 && k % P == 0); i++) tick();
    chk("reach_ch1", (k / P) % N == 1 && k % P == 0, 1);
    b.wr_en = 1; b.wr_addr = 1; b.wr_data = 6;
    tick();
    b.wr_en = 0;
    tick();
    chk("live_write", 32'(b.level_out), 32'd6);
    for (int i = 0; i < 4 * N * P && !((k / P) % N == 2 && k % P == 1); i++) tick();
    chk("reach_ch2", (k / P) % N == 2 && k % P == 1, 1);
    b.en = 0;
    tick();
    chk("dark_on_disable", 32'(b.digit_sel), 32'h0);
    chk("no_frame_on_disable", 32'(b.frame_done), 32'h0);
    b.en = 1;
    repeat (N * P + 2) tick();
    for (int i = 0; i < 4 * N * P && !((k / P) % N == 1 && k % P == 2); i++) tick();
    chk("reach_ch1_rst", (k / P) % N == 1 && k % P == 2, 1);
    rst = 1; b.wr_en = 1; b.wr_addr = 0; b.wr_data = 7;
    tick();
    rst = 0; b.wr_en = 0;
    chk("rst_state", 32'(u.r_state), 32'(IDLE));
    for (int c = 0; c < N; c++) chk("rst_level", 32'(u.u_rf.r_mem[c]), 32'h0);
    repeat (N * P + 2) tick();
    b.en = 0;
    for (int c = 0; c < 3; c++) begin
      b3.wr_en = 1; b3.wr_addr = 2'(c); b3.wr_data = 3'(2 * c + 2);
      m3[c] = 3'(2 * c + 2);
      @(posedge clk); #1;
    end
    b3.wr_addr = 3; b3.wr_data = 7;
    @(posedge clk); #1;
    b3.wr_en = 0;
    b3.en = 1;
    for (int j = 0; j < 3 * P + 2; j++) begin
      int i;
      @(posedge clk); #1;
      i = e_idx(3, j);
      chk("n3_sel", 32'(b3.digit_sel), 32'(e_sel(3, j)));
      chk("n3_level", 32'(b3.level_out), i < 0 ? 0 : 32'(m3[i]));
      chk("n3_frame", 32'(b3.frame_done), 32'(e_frm(3, j)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
